// File: rtl/sample_loader.sv
// sample_loader
// Streams NUM_SAMPLES signed 16-bit samples from a valid/ready source into an
// Avalon-MM FFT slave as sign-extended 32-bit words at addresses 0.., then
// writes 0 to START_ADDR to kick off the transform and pulses done.
// Each data write is held for HOLD_CYCLES cycles and followed by a one-cycle
// idle gap on the bus. All outputs are registered.
//
// Build option: define SAMPLE_LOADER_ZERO_PAD_EN to pad the frame with zero
// words up to FRAME_LEN. Without it the frame ends after the last sample.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   arm              frame-start request, honoured only while idle
//   in_valid/in_data upstream sample stream (16-bit signed)
//   in_ready         loader accepts a sample this cycle
//   slave_*          Avalon-MM master signals to the FFT slave (read unused)
//   busy             high whenever a frame is in progress
//   done             one-cycle pulse at the end of a frame
module sample_loader #(
  parameter int         NUM_SAMPLES = 256,
  parameter int         FRAME_LEN   = 511,
  parameter int         HOLD_CYCLES = 3,
  parameter logic [8:0] START_ADDR  = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        slave_write,
  output logic        slave_read,
  output logic        slave_chipselect,
  output logic [8:0]  slave_address,
  output logic [31:0] slave_writedata,
  output logic        busy,
  output logic        done
);

`ifdef SAMPLE_LOADER_ZERO_PAD_EN
  localparam int LIMIT = FRAME_LEN;
`else
  localparam int LIMIT = NUM_SAMPLES;
`endif

  localparam logic [10:0] LIMIT_L = 11'(LIMIT);
  localparam logic [10:0] NUM_L   = 11'(NUM_SAMPLES);
  localparam int          HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, GAP, START, DONE} state_t;

  state_t             state_reg, state_next;
  logic [9:0]         cnt_reg, cnt_next;
  logic [31:0]        data_reg, data_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;

  logic               ready_reg, ready_next;
  logic               write_reg, write_next;
  logic               cs_reg, cs_next;
  logic [8:0]         addr_reg, addr_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic [10:0]        cnt_inc;

  assign cnt_inc = {1'b0, cnt_reg} + 11'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    hold_next  = hold_reg;

    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next = FETCH;
          cnt_next   = '0;
        end
      end
      FETCH: begin
        if ({1'b0, cnt_reg} >= NUM_L) begin
          state_next = WRITE;
          data_next  = '0;
          hold_next  = '0;
        end else if (in_valid && in_ready) begin
          state_next = WRITE;
          data_next  = {{16{in_data[15]}}, in_data};
          hold_next  = '0;
        end
      end
      WRITE: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = GAP;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      GAP: begin
        cnt_next = cnt_reg + 10'd1;
        if (cnt_inc < LIMIT_L) begin
          if (cnt_inc < NUM_L) begin
            state_next = FETCH;
          end else begin
            // Padding words need no handshake, so the fetch decision is
            // resolved here and the next write follows the gap directly.
            state_next = WRITE;
            data_next  = '0;
            hold_next  = '0;
          end
        end else begin
          state_next = START;
        end
      end
      START: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Registered outputs are decoded from the state being entered so that
    // they line up with that state on the following cycle.
    ready_next = 1'b0;
    write_next = 1'b0;
    cs_next    = 1'b0;
    addr_next  = '0;
    wdata_next = '0;
    busy_next  = (state_next != IDLE);
    done_next  = 1'b0;

    case (state_next)
      FETCH: ready_next = ({1'b0, cnt_next} < NUM_L);
      WRITE: begin
        write_next = 1'b1;
        cs_next    = 1'b1;
        addr_next  = cnt_next[8:0];
        wdata_next = data_next;
      end
      START: begin
        write_next = 1'b1;
        cs_next    = 1'b1;
        addr_next  = START_ADDR;
      end
      DONE: done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      hold_reg  <= '0;
      ready_reg <= 1'b0;
      write_reg <= 1'b0;
      cs_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      hold_reg  <= hold_next;
      ready_reg <= ready_next;
      write_reg <= write_next;
      cs_reg    <= cs_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign in_ready         = ready_reg;
  assign slave_write      = write_reg;
  assign slave_read       = 1'b0;
  assign slave_chipselect = cs_reg;
  assign slave_address    = addr_reg;
  assign slave_writedata  = wdata_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;

endmodule

// File: tb/tb_sample_loader.sv
module tb_sample_loader;
  localparam int NS = 256;
  localparam int FL = 511;
  localparam int H  = 3;
`ifdef SAMPLE_LOADER_ZERO_PAD_EN
  localparam int WORDS    = FL;
  localparam int DONE_LAT = 2302;  // 511*(3+1)+256+2
  localparam int N_WRITES = 512;   // 511 data words + start command
  localparam int S_WORDS  = 6;
`else
  localparam int WORDS    = NS;
  localparam int DONE_LAT = 1282;  // 256*(3+2)+2
  localparam int N_WRITES = 257;   // 256 samples + start command
  localparam int S_WORDS  = 4;
`endif

  logic        clk = 1'b0;
  logic        rst, arm, in_valid;
  logic [15:0] in_data;
  logic        in_ready, slave_write, slave_read, slave_chipselect, busy, done;
  logic [8:0]  slave_address;
  logic [31:0] slave_writedata;

  logic        arm_s;
  logic        in_valid_s = 1'b1;
  logic [15:0] in_data_s  = 16'hFFF5;
  logic        in_ready_s, write_s, read_s, cs_s, busy_s, done_s;
  logic [8:0]  addr_s;
  logic [31:0] wdata_s;

  always #5 clk = ~clk;

  sample_loader dut (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .slave_write(slave_write), .slave_read(slave_read),
    .slave_chipselect(slave_chipselect), .slave_address(slave_address),
    .slave_writedata(slave_writedata), .busy(busy), .done(done)
  );

  sample_loader #(.NUM_SAMPLES(4), .FRAME_LEN(6), .HOLD_CYCLES(3), .START_ADDR(9'h1FF)) dut_s (
    .clk(clk), .rst(rst), .arm(arm_s), .in_valid(in_valid_s), .in_data(in_data_s),
    .in_ready(in_ready_s), .slave_write(write_s), .slave_read(read_s),
    .slave_chipselect(cs_s), .slave_address(addr_s),
    .slave_writedata(wdata_s), .busy(busy_s), .done(done_s)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference model: on an accepted arm the whole frame is laid out as a list
  // of bus cycles; one entry is consumed per clock, except that a sample-wait
  // entry stays put until the source offers a sample.
  typedef enum {K_FETCH, K_WRITE, K_GAP, K_START, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    addr;
    bit    pad;
  } tok_t;

  tok_t        sched[$];
  tok_t        m_cur;
  bit          m_active = 1'b0;
  logic [31:0] m_sample = '0;

  task automatic build_frame();
    tok_t t;
    sched.delete();
    for (int w = 0; w < WORDS; w++) begin
      if (w < NS) begin
        t.kind = K_FETCH; t.addr = 0; t.pad = 1'b0;
        sched.push_back(t);
      end
      for (int h = 0; h < H; h++) begin
        t.kind = K_WRITE; t.addr = w; t.pad = (w >= NS);
        sched.push_back(t);
      end
      t.kind = K_GAP; t.addr = 0; t.pad = 1'b0;
      sched.push_back(t);
    end
    t.kind = K_START; t.addr = 9'h1FF; t.pad = 1'b0;
    sched.push_back(t);
    t.kind = K_DONE; t.addr = 0; t.pad = 1'b0;
    sched.push_back(t);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      sched.delete();
      m_active = 1'b0;
    end else if (!m_active) begin
      if (arm) begin
        build_frame();
        m_cur    = sched.pop_front();
        m_active = 1'b1;
      end
    end else if (!(m_cur.kind == K_FETCH && !in_valid)) begin
      if (m_cur.kind == K_FETCH) m_sample = {{16{in_data[15]}}, in_data};
      if (sched.size() == 0) m_active = 1'b0;
      else m_cur = sched.pop_front();
    end
  end

  function automatic logic [46:0] model_out();
    logic rdy, wr, cs, bsy, dn;
    logic [8:0]  a;
    logic [31:0] d;
    rdy = 1'b0; wr = 1'b0; cs = 1'b0; bsy = 1'b0; dn = 1'b0; a = '0; d = '0;
    if (m_active) begin
      bsy = 1'b1;
      case (m_cur.kind)
        K_FETCH: rdy = 1'b1;
        K_WRITE: begin
          wr = 1'b1; cs = 1'b1; a = 9'(m_cur.addr);
          d = m_cur.pad ? 32'h0 : m_sample;
        end
        K_START: begin wr = 1'b1; cs = 1'b1; a = 9'h1FF; end
        K_DONE:  dn = 1'b1;
        default: ;
      endcase
    end
    return {rdy, wr, 1'b0, cs, a, d, bsy, dn};
  endfunction

  function automatic logic [46:0] dut_out();
    return {in_ready, slave_write, slave_read, slave_chipselect, slave_address,
            slave_writedata, busy, done};
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("cycle_model", 64'(dut_out()), 64'(model_out()));
  end

  // Bus event monitors
  int   n_wr = 0, n_start_wr = 0, n_done = 0;
  logic prev_write = 1'b0;
  logic prev_write_s = 1'b0;
  logic [8:0]  s_addr[$];
  logic [31:0] s_data[$];
  int   s_done = 0;

  always @(negedge clk) begin
    if (slave_write === 1'b1 && !prev_write) begin
      n_wr++;
      if (slave_address == 9'h1FF) n_start_wr++;
    end
    if (done === 1'b1) n_done++;
    prev_write = (slave_write === 1'b1);
    if (write_s === 1'b1 && !prev_write_s) begin
      s_addr.push_back(addr_s);
      s_data.push_back(wdata_s);
    end
    if (done_s === 1'b1) s_done++;
    prev_write_s = (write_s === 1'b1);
  end

  initial begin
    int  t_arm, done_cyc, w0, s0, d0;
    bit  seen;

    rst = 1'b1; arm = 1'b0; in_valid = 1'b0; in_data = '0; arm_s = 1'b0;
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1; arm = 1'b1;      // reset and arm together
    @(posedge clk); #1; arm = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'(dut_out()), 64'h0);
    check("rst_over_arm_busy", 64'(busy), 64'h0);

    // Frame 1: continuous stream of 16'h8001
    in_valid = 1'b1; in_data = 16'h8001;
    w0 = n_wr; s0 = n_start_wr;
    @(posedge clk); #1; arm = 1'b1; arm_s = 1'b1; t_arm = cyc;
    @(posedge clk); #1; arm = 1'b0; arm_s = 1'b0;
    @(negedge clk);
    check("first_fetch_ready", 64'(in_ready), 64'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sext_hold", 64'({slave_write, slave_chipselect, slave_address, slave_writedata}),
            64'({1'b1, 1'b1, 9'h000, 32'hFFFF8001}));
    end
    @(negedge clk);
    check("gap_idle", 64'({slave_write, slave_chipselect, slave_address, slave_writedata}), 64'h0);
    seen = 1'b0; done_cyc = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; done_cyc = cyc; end
    end
    check("frame1_done_seen", 64'(seen), 64'h1);
    check("done_latency", 64'(done_cyc - t_arm), 64'(DONE_LAT));
    @(negedge clk);
    check("frame1_write_count", 64'(n_wr - w0), 64'(N_WRITES));
    check("frame1_start_write", 64'(n_start_wr - s0), 64'h1);
    $display("frame 1: done %0d cycles after arm, %0d writes", done_cyc - t_arm, n_wr - w0);

    // Small instance: NUM_SAMPLES=4, FRAME_LEN=6
    check("small_write_count", 64'(s_addr.size()), 64'(S_WORDS + 1));
    check("small_done_count", 64'(s_done), 64'h1);
    for (int i = 0; i < s_addr.size() && i <= S_WORDS; i++) begin
      check("small_addr", 64'(s_addr[i]), (i < S_WORDS) ? 64'(i) : 64'h1FF);
      check("small_data", 64'(s_data[i]), (i < 4) ? 64'hFFFFFFF5 : 64'h0);
    end
    $display("small frame: %0d writes", s_addr.size());

    // Frame 2: stalling source, random data, arm pulses while busy
    d0 = n_done;
    @(posedge clk); #1; arm = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(posedge clk); #1;
      arm      = ($urandom_range(0, 40) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 16'($urandom);
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    @(posedge clk); #1; arm = 1'b0; in_valid = 1'b0;
    check("frame2_done_seen", 64'(seen), 64'h1);
    repeat (20) @(negedge clk);
    check("one_done_per_arm", 64'(n_done - d0), 64'h1);
    check("idle_after_frame2", 64'(busy), 64'h0);
    $display("frame 2: %0d done pulses", n_done - d0);

    // Frame 3: stall in FETCH, then reset during the write to address 100
    in_data = 16'h1234;
    w0 = n_wr;
    @(posedge clk); #1; arm = 1'b1;
    @(posedge clk); #1; arm = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("stall_hold", 64'({in_ready, slave_write, slave_address}), 64'({1'b1, 1'b0, 9'h000}));
    end
    check("stall_no_write", 64'(n_wr - w0), 64'h0);
    in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (slave_write === 1'b1 && slave_address == 9'd100) seen = 1'b1;
    end
    check("reach_addr100", 64'(seen), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_midframe_outputs", 64'(dut_out()), 64'h0);
    rst = 1'b0;
    w0 = n_wr; s0 = n_start_wr; d0 = n_done;
    repeat (50) @(negedge clk);
    check("no_write_after_rst", 64'(n_wr - w0), 64'h0);
    check("no_start_after_rst", 64'(n_start_wr - s0), 64'h0);
    check("no_done_after_rst", 64'(n_done - d0), 64'h0);
    $display("frame 3: abandoned by reset at address 100");

    // Frame 4: restart from address 0 after the abort
    @(posedge clk); #1; arm = 1'b1;
    @(posedge clk); #1; arm = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (slave_write === 1'b1) seen = 1'b1;
    end
    check("restart_write_seen", 64'(seen), 64'h1);
    check("restart_addr0", 64'(slave_address), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("restart_done", 64'(seen), 64'h1);
    @(negedge clk);
    $display("frame 4: restarted at address 0, done seen=%0d", seen);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
